// File: rtl/fft_stage_ctrl.sv
// Sequencer for the 32-point radix-2 FFT: launches butterflies, steps the iteration counter, walks 5 stages.
// Optional WAIT watchdog enabled by defining FFT_TIMEOUT_EN.
module fft_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       n_reset_i,
  input  logic       start_i,
  input  logic       bfly_done_i,
  input  logic [3:0] iteration_count_i,
  input  logic       stage_strobe_i,
  output logic       iteration_strobe_o,
  output logic       iter_clear_o,
  output logic       bfly_start_o,
  output logic [4:0] addr_a_o,
  output logic [4:0] addr_b_o,
  output logic [3:0] twiddle_idx_o,
  output logic [2:0] stage_count_o,
  output logic       busy_o,
  output logic       fft_done_o,
  output logic       timeout_err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ABORT  = 3'd7;

  localparam logic [2:0] LAST_STAGE = 3'd4;

  logic [2:0] state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic       wait_expired;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LAUNCH;
          stage_d = '0;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bfly_done_i) begin
          state_d = S_STROBE;
        end else if (wait_expired) begin
          state_d = S_ABORT;
        end
      end
      S_STROBE: state_d = S_CHECK;
      // The counter has already absorbed the strobe, so its rollover flag is current here.
      S_CHECK:  state_d = stage_strobe_i ? S_CLEAR : S_LAUNCH;
      S_CLEAR: begin
        if (stage_q == LAST_STAGE) begin
          state_d = S_DONE;
        end else begin
          stage_d = stage_q + 3'd1;
          state_d = S_LAUNCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q <= S_IDLE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

`ifdef FFT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  assign wait_expired = (state_q == S_WAIT) &&
                        (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    if (state_q == S_LAUNCH) begin
      wait_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if ((state_q == S_IDLE) && start_i) begin
      err_d = 1'b0;
    end else if (wait_expired && !bfly_done_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign timeout_err_o = err_q;
`else
  assign wait_expired  = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  assign bfly_start_o       = (state_q == S_LAUNCH);
  assign iteration_strobe_o = (state_q == S_STROBE);
  assign iter_clear_o       = (state_q == S_CLEAR) || (state_q == S_ABORT);
  assign fft_done_o         = (state_q == S_DONE);
  assign busy_o             = (state_q != S_IDLE);
  assign stage_count_o      = stage_q;

  // Butterfly k of stage s pairs samples span apart inside group k>>s.
  logic [4:0] span;
  logic [3:0] pos_mask, pos, grp;

  always_comb begin
    span          = 5'd1 << stage_q;
    pos_mask      = 4'(span - 5'd1);
    pos           = iteration_count_i & pos_mask;
    grp           = iteration_count_i >> stage_q;
    addr_a_o      = ({1'b0, grp} << (stage_q + 3'd1)) + {1'b0, pos};
    addr_b_o      = addr_a_o + span;
    twiddle_idx_o = pos << (3'd4 - stage_q);
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Randomised bench for fft_stage_ctrl with a behavioural iteration-counter/butterfly model and address reference.
`timescale 1ns/1ps
module tb_fft_stage_ctrl;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       n_reset, start, bfly_done, stage_strobe;
  logic [3:0] iteration_count;
  logic       iteration_strobe, iter_clear, bfly_start, busy, fft_done, timeout_err;
  logic [4:0] addr_a, addr_b;
  logic [3:0] twiddle_idx;
  logic [2:0] stage_count;

  fft_stage_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i              (clk),
    .n_reset_i          (n_reset),
    .start_i            (start),
    .bfly_done_i        (bfly_done),
    .iteration_count_i  (iteration_count),
    .stage_strobe_i     (stage_strobe),
    .iteration_strobe_o (iteration_strobe),
    .iter_clear_o       (iter_clear),
    .bfly_start_o       (bfly_start),
    .addr_a_o           (addr_a),
    .addr_b_o           (addr_b),
    .twiddle_idx_o      (twiddle_idx),
    .stage_count_o      (stage_count),
    .busy_o             (busy),
    .fft_done_o         (fft_done),
    .timeout_err_o      (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int cnt_m = 0;
  bit ss_m  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sample point is #1 after the edge; inputs for the new cycle are set here, outputs read #1 later.
  task automatic step();
    logic p_strobe, p_clear;
    p_strobe = iteration_strobe;
    p_clear  = iter_clear;
    @(posedge clk);
    cyc++;
    #1;
    if (!n_reset || p_clear) begin
      cnt_m = 0;
      ss_m  = 1'b0;
    end else if (p_strobe) begin
      ss_m  = (cnt_m == 15);
      cnt_m = (cnt_m + 1) % 16;
    end else begin
      ss_m = 1'b0;
    end
    iteration_count = 4'(cnt_m);
    stage_strobe    = ss_m;
  endtask

  function automatic void ref_addr(input int s, input int k, output int a, output int b, output int t);
    int span;
    span = 1 << s;
    a = (k / span) * 2 * span + k % span;
    b = a + span;
    t = (k % span) * (16 / span);
  endfunction

  task automatic do_reset();
    n_reset = 1'b0;
    start = 1'b0; bfly_done = 1'b0; stage_strobe = 1'b0;
    cnt_m = 0; ss_m = 1'b0; iteration_count = 4'd0;
    repeat (2) step();
    #2 n_reset = 1'b1;
    #1;
  endtask

  task automatic run_xform(input int mind, input int maxd, input bit noisy, input int abort_n);
    int s0, n_launch, n_strobe, n_clear, total, launch_cyc, done_at, d;
    int es, ek, ea, eb, et;
    bit finished;
    n_launch = 0; n_strobe = 0; n_clear = 0; total = 0;
    launch_cyc = -100; done_at = -100; finished = 1'b0;
    es = 0; ek = 0; ea = 0; eb = 0; et = 0;
    step();
    start = 1'b1; bfly_done = 1'b0;
    #1;
    s0 = cyc;
    for (int t = 0; t < 4000 && !finished; t++) begin
      step();
      start     = noisy ? ($urandom_range(0, 2) == 0) : 1'b0;
      bfly_done = (cyc == done_at) || (noisy && (cyc == done_at + 1 || cyc == done_at + 2));
      if (noisy && cyc > launch_cyc && cyc < done_at && $urandom_range(0, 1) == 1)
        stage_strobe = 1'b1;
      if (abort_n >= 0 && n_launch == abort_n + 1 && cyc == launch_cyc + 3) begin
        n_reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_bfly_start", bfly_start, 0);
        check("rst_iter_strobe", iteration_strobe, 0);
        check("rst_iter_clear", iter_clear, 0);
        check("rst_fft_done", fft_done, 0);
        check("rst_stage", stage_count, 0);
        start = 1'b0; bfly_done = 1'b0; stage_strobe = 1'b0;
        cnt_m = 0; ss_m = 1'b0; iteration_count = 4'd0;
        return;
      end
      #1;
      if (bfly_start) begin
        es = n_launch / 16;
        ek = n_launch % 16;
        ref_addr(es, ek, ea, eb, et);
        check("launch_stage", stage_count, es);
        check("launch_k", iteration_count, ek);
        check("launch_addr_a", addr_a, ea);
        check("launch_addr_b", addr_b, eb);
        check("launch_twiddle", twiddle_idx, et);
        d = (abort_n >= 0 && n_launch == abort_n) ? 10 : $urandom_range(mind, maxd);
        total += 4 + d;
        launch_cyc = cyc;
        done_at = cyc + 1 + d;
        n_launch++;
      end
      if (iteration_strobe) begin
        n_strobe++;
        check("strobe_cycle", cyc, done_at + 1);
        check("strobe_addr_a", addr_a, ea);
        check("strobe_addr_b", addr_b, eb);
        check("strobe_twiddle", twiddle_idx, et);
      end
      if (iter_clear) n_clear++;
      if (fft_done) begin
        check("done_cycle", cyc, s0 + 1 + total + 5);
        check("n_bfly_start", n_launch, 80);
        check("n_iter_strobe", n_strobe, 80);
        check("n_iter_clear", n_clear, 5);
        check("done_stage", stage_count, 4);
        finished = 1'b1;
      end
    end
    if (!finished) check("xform_finished", 0, 1);
    step();
    start = 1'b0; bfly_done = 1'b0;
    #1;
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    logic seen;
    int   s0, clr_cyc, bad_cnt;
    bit   saw_done;

    n_reset = 1'b0; start = 1'b0; bfly_done = 1'b0;
    stage_strobe = 1'b0; iteration_count = 4'd0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_bfly_start", bfly_start, 0);
    check("reset_iter_strobe", iteration_strobe, 0);
    check("reset_iter_clear", iter_clear, 0);
    check("reset_fft_done", fft_done, 0);
    check("reset_stage", stage_count, 0);
    check("reset_timeout_err", timeout_err, 0);
    check("reset_addr_a", addr_a, 0);
    check("reset_addr_b", addr_b, 1);
    check("reset_twiddle", twiddle_idx, 0);
    #10 n_reset = 1'b1;

    seen = 1'b0;
    repeat (10) begin
      step();
      #1;
      seen = seen | busy | bfly_start | iteration_strobe | iter_clear | fft_done;
    end
    check("idle_quiet", seen, 0);

    run_xform(0, 0, 1'b0, -1);
    run_xform(7, 7, 1'b0, -1);
    run_xform(0, 5, 1'b1, -1);
    run_xform(0, 3, 1'b0, $urandom_range(48, 63));
    do_reset();
    run_xform(0, 2, 1'b1, -1);

`ifdef FFT_TIMEOUT_EN
    step();
    start = 1'b1; bfly_done = 1'b0;
    #1;
    s0 = cyc; clr_cyc = -1; saw_done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      step();
      start = 1'b0;
      #1;
      if (iter_clear && clr_cyc < 0) clr_cyc = cyc;
      if (fft_done) saw_done = 1'b1;
      if (!busy) break;
    end
    check("to_clear_cycle", clr_cyc, s0 + 66);
    check("to_idle_cycle", cyc, s0 + 67);
    check("to_err_set", timeout_err, 1);
    check("to_no_done", saw_done, 0);
    step();
    start = 1'b1;
    #1;
    step();
    start = 1'b0;
    #1;
    check("to_err_cleared", timeout_err, 0);
    do_reset();
`else
    step();
    start = 1'b1; bfly_done = 1'b0;
    #1;
    bad_cnt = 0;
    for (int t = 0; t < 100; t++) begin
      step();
      start = 1'b0;
      #1;
      if (!busy || iter_clear || timeout_err || fft_done) bad_cnt++;
    end
    check("stall_holds", bad_cnt, 0);
    check("stall_busy", busy, 1);
    do_reset();
`endif
    check("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
